// File: rtl/ysyx_25060170_wbu_hs.sv
// ysyx_25060170_wbu_hs: write-back unit with load extension, retire pulse and retire counter
module ysyx_25060170_wbu_hs #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    exu_result_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    csr_rdata_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [1:0]         regS,
  input  logic               RegW,
  input  logic [2:0]         ld_funct3_i,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_rerr,
  output logic               reg_write_en_o,
  output logic [RADDR_W-1:0] reg_write_addr_o,
  output logic [XLEN-1:0]    reg_write_data_o,
  output logic               commit_o,
  output logic [XLEN-1:0]    commit_pc_o,
  output logic               commit_err_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    res_q, pc_q, csr_q, ld_q, ld_d;
  logic [RADDR_W-1:0] rd_q;
  logic [1:0]         regs_q;
  logic               regw_q, err_q;
  logic [2:0]         f3_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        sh, ext;
  logic               hs, write;
  assign in_ready = state_q == IDLE;
  assign hs       = in_valid & in_ready;
  assign write    = state_q == WRITE;
  // Extension is done at 64 bits then truncated, so on XLEN=32 ld/lwu/lw all collapse to the full word.
  always_comb begin
    sh = 64'(mem_rdata >> {res_q[OFF_W-1:0], 3'b000});
    case (f3_q)
      3'b000:  ext = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ext = {{32{sh[31]}}, sh[31:0]};
      3'b011:  ext = sh;
      3'b100:  ext = {56'd0, sh[7:0]};
      3'b101:  ext = {48'd0, sh[15:0]};
      3'b110:  ext = {32'd0, sh[31:0]};
      default: ext = '0;
    endcase
    ld_d = XLEN'(ext);
  end
  always_comb begin
    state_d = state_q == IDLE     ? (in_valid ? (regS == 2'd1 ? WAIT_MEM : WRITE) : IDLE) :
              state_q == WAIT_MEM ? (mem_rvalid ? WRITE : WAIT_MEM) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      pc_q    <= '0;
      csr_q   <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      regs_q  <= '0;
      regw_q  <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        res_q  <= exu_result_i;
        pc_q   <= pc_i;
        csr_q  <= csr_rdata_i;
        rd_q   <= rd_i;
        regs_q <= regS;
        regw_q <= RegW;
        f3_q   <= ld_funct3_i;
        ld_q   <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == WAIT_MEM && mem_rvalid) begin
        ld_q  <= ld_d;
        err_q <= mem_rerr;
      end
      if (write) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // Outputs are masked while rst is high so an aborted WRITE never reaches the register file.
  assign reg_write_en_o   = write & ~rst & regw_q & |rd_q & ~err_q;
  assign reg_write_addr_o = rd_q;
  assign reg_write_data_o = regs_q == 2'd0 ? res_q :
                            regs_q == 2'd1 ? ld_q  :
                            regs_q == 2'd2 ? pc_q + XLEN'(4) : csr_q;
  assign commit_o         = write & ~rst;
  assign commit_pc_o      = pc_q;
  assign commit_err_o     = write & ~rst & err_q;
  assign retire_cnt_o     = cnt_q;
endmodule

// File: tb/tb_ysyx_25060170_wbu_hs.sv
// tb_ysyx_25060170_wbu_hs: drives a 32-bit and a 64-bit (4-bit counter) instance with shared stimulus
module tb_ysyx_25060170_wbu_hs;
  typedef struct {
    logic [1:0]  regs;
    logic [4:0]  rd;
    logic        regw;
    logic [63:0] a, pc, csr, rdata;
    logic [2:0]  f3;
    logic        rerr;
    int          dly;
    logic [63:0] e32, e64;
    logic        en, err;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, regw = 1'b0, mem_rvalid = 1'b0, mem_rerr = 1'b0;
  logic [63:0] exu = '0, pc = '0, csr = '0, mem_rdata = '0;
  logic [4:0] rd = '0;
  logic [1:0] regs = '0;
  logic [2:0] f3 = '0;
  logic rdy32, en32, com32, cerr32, rdy64, en64, com64, cerr64;
  logic [4:0] addr32, addr64;
  logic [31:0] data32, cpc32;
  logic [63:0] data64, cpc64, cnt32;
  logic [3:0] cnt64;
  int n_chk = 0, n_fail = 0, retired = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  ysyx_25060170_wbu_hs #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .exu_result_i(exu[31:0]), .pc_i(pc[31:0]), .csr_rdata_i(csr[31:0]), .rd_i(rd),
    .regS(regs), .RegW(regw), .ld_funct3_i(f3), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]), .mem_rerr(mem_rerr), .reg_write_en_o(en32),
    .reg_write_addr_o(addr32), .reg_write_data_o(data32), .commit_o(com32),
    .commit_pc_o(cpc32), .commit_err_o(cerr32), .retire_cnt_o(cnt32));

  ysyx_25060170_wbu_hs #(.XLEN(64), .RADDR_W(5), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .exu_result_i(exu), .pc_i(pc), .csr_rdata_i(csr), .rd_i(rd),
    .regS(regs), .RegW(regw), .ld_funct3_i(f3), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr), .reg_write_en_o(en64),
    .reg_write_addr_o(addr64), .reg_write_data_o(data64), .commit_o(com64),
    .commit_pc_o(cpc64), .commit_err_o(cerr64), .retire_cnt_o(cnt64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference load: pick the addressed bytes, then sign/zero extend by access size.
  function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] addr,
                                           input logic [63:0] rdata, input logic [2:0] f3v);
    logic [63:0] w, v, mask;
    int off, sz;
    bit sg;
    if (f3v == 3'b111) return '0;
    w   = (xlen == 32) ? (rdata & 64'hFFFF_FFFF) : rdata;
    off = int'(addr % 64'(xlen / 8));
    v   = w >> (8 * off);
    sz  = (f3v[1:0] == 2'd0) ? 1 : (f3v[1:0] == 2'd1) ? 2 : (f3v[1:0] == 2'd2) ? 4 : 8;
    sg  = (f3v[2] == 1'b0) && (f3v != 3'b011);
    if (xlen == 32 && sz > 4) sz = 4;
    mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v = v & mask;
    if (sg && v[8 * sz - 1]) v = v | ~mask;
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] ref_wb(input int xlen, input vec_t v);
    logic [63:0] m;
    m = (xlen == 32) ? 64'hFFFF_FFFF : '1;
    case (v.regs)
      2'd0:    return v.a & m;
      2'd1:    return ref_load(xlen, v.a, v.rdata, v.f3);
      2'd2:    return (v.pc + 64'd4) & m;
      default: return v.csr & m;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready32"}, 64'(rdy32), 64'd1);
    chk({tag, "_ready64"}, 64'(rdy64), 64'd1);
    chk({tag, "_commit32"}, 64'(com32), 64'd0);
    chk({tag, "_commit64"}, 64'(com64), 64'd0);
    chk({tag, "_en32"}, 64'(en32), 64'd0);
    chk({tag, "_cerr64"}, 64'(cerr64), 64'd0);
    chk({tag, "_cnt32"}, cnt32, 64'(retired));
    chk({tag, "_cnt64"}, 64'(cnt64), 64'(retired % 16));
  endtask

  // One instruction: handshake (with a stray mem_rvalid that must be ignored), optional load wait, write check.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, "_ready_in"}, 64'(rdy32 & rdy64), 64'd1);
    in_valid = 1'b1; regs = v.regs; rd = v.rd; regw = v.regw; exu = v.a; pc = v.pc;
    csr = v.csr; f3 = v.f3; mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0;
    if (v.regs == 2'd1) begin
      for (int i = 0; i < v.dly; i++) begin
        chk({tag, "_wait_ready"}, 64'(rdy32 | rdy64), 64'd0);
        chk({tag, "_wait_commit"}, 64'(com32 | com64), 64'd0);
        @(negedge clk);
      end
      chk({tag, "_wait_ready"}, 64'(rdy32 | rdy64), 64'd0);
      mem_rvalid = 1'b1; mem_rdata = v.rdata; mem_rerr = v.rerr;
      @(posedge clk); @(negedge clk);
      mem_rvalid = 1'b0; mem_rerr = 1'b0;
    end
    chk({tag, "_commit32"}, 64'(com32), 64'd1);
    chk({tag, "_commit64"}, 64'(com64), 64'd1);
    chk({tag, "_en32"}, 64'(en32), 64'(v.en));
    chk({tag, "_en64"}, 64'(en64), 64'(v.en));
    chk({tag, "_addr32"}, 64'(addr32), 64'(v.rd));
    chk({tag, "_addr64"}, 64'(addr64), 64'(v.rd));
    chk({tag, "_data32"}, 64'(data32), v.e32 & 64'hFFFF_FFFF);
    chk({tag, "_data64"}, data64, v.e64);
    chk({tag, "_pc32"}, 64'(cpc32), v.pc & 64'hFFFF_FFFF);
    chk({tag, "_pc64"}, cpc64, v.pc);
    chk({tag, "_cerr32"}, 64'(cerr32), 64'(v.err));
    chk({tag, "_cerr64"}, 64'(cerr64), 64'(v.err));
    retired++;
    @(negedge clk);
    check_idle({tag, "_after"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int commits;
    tbl[0]  = '{0, 5, 1, 64'h1234_5678, 64'h1000, 0, 0, 3'b000, 0, 0, 64'h1234_5678, 64'h1234_5678, 1, 0};
    tbl[1]  = '{1, 7, 1, 64'h8000_0003, 64'h1004, 0, 64'h80FF_FF7F, 3'b000, 0, 3, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1, 0};
    tbl[2]  = '{1, 8, 1, 64'h6, 64'h1008, 0, 64'hBEEF_0000_0000_0000, 3'b101, 0, 1, 0, 64'hBEEF, 1, 0};
    tbl[3]  = '{2, 0, 1, 0, 64'h100, 0, 0, 3'b000, 0, 0, 64'h104, 64'h104, 0, 0};
    tbl[4]  = '{1, 3, 1, 64'h10, 64'h200, 0, 64'hDEAD_BEEF, 3'b010, 1, 2, 64'hDEAD_BEEF, 64'hFFFF_FFFF_DEAD_BEEF, 0, 1};
    tbl[5]  = '{3, 9, 1, 0, 64'h300, 64'hCAFE_F00D_1122_3344, 0, 3'b000, 0, 0, 64'h1122_3344, 64'hCAFE_F00D_1122_3344, 1, 0};
    tbl[6]  = '{1, 10, 1, 64'h4, 64'h304, 0, 64'h1111_1111_2222_2222, 3'b011, 0, 0, 64'h2222_2222, 64'h1111_1111, 1, 0};
    tbl[7]  = '{1, 11, 1, 64'h1, 64'h308, 0, 64'h1234_5678, 3'b111, 0, 1, 0, 0, 1, 0};
    tbl[8]  = '{2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 12, 0, 64'h2, 64'h30C, 0, 64'h8001_0000, 3'b001, 0, 0, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 0, 0};
    tbl[10] = '{1, 13, 1, 64'h1, 64'h310, 0, 64'hF000, 3'b100, 0, 0, 64'hF0, 64'hF0, 1, 0};
    tbl[11] = '{1, 14, 1, 64'h0, 64'h314, 0, 64'h8000_0000, 3'b110, 0, 2, 64'h8000_0000, 64'h8000_0000, 1, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_commit", 64'(com32 | com64 | en32 | en64 | cerr32 | cerr64), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: in_valid held high accepts every other cycle.
    @(negedge clk);
    in_valid = 1'b1; regs = 2'd0; rd = 5'd6; regw = 1'b1; exu = 64'h55; pc = 64'h400;
    commits = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_ready%0d", k), 64'(rdy32), 64'((k % 2) == 0));
      chk($sformatf("b2b_commit%0d", k), 64'(com64), 64'((k % 2) == 1));
      commits += int'(com32);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    retired += 4;
    chk("b2b_writes", 64'(commits), 64'd4);
    check_idle("b2b");

    // Reset while waiting for memory, then a late mem_rvalid.
    in_valid = 1'b1; regs = 2'd1; rd = 5'd4; regw = 1'b1; exu = 64'h0; f3 = 3'b010;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("rstwait_ready", 64'(rdy32 | rdy64), 64'd0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    retired = 0;
    chk("rstwait_commit", 64'(com32 | com64), 64'd0);
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    check_idle("rstwait");

    // Reset landing in the WRITE cycle aborts the write.
    in_valid = 1'b1; regs = 2'd0; rd = 5'd6; regw = 1'b1; exu = 64'h99;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rstwrite_commit", 64'(com32 | com64), 64'd0);
    chk("rstwrite_en", 64'(en32 | en64), 64'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rstwrite");

    // Random traffic against the reference model; also carries the 4-bit counter across its wrap.
    for (int i = 0; i < 40; i++) begin
      v.regs  = 2'($urandom_range(0, 3));
      v.rd    = 5'($urandom);
      v.regw  = 1'($urandom);
      v.a     = {$urandom, $urandom};
      v.pc    = {$urandom, $urandom};
      v.csr   = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.f3    = 3'($urandom);
      v.rerr  = ($urandom_range(0, 3) == 0);
      v.dly   = $urandom_range(0, 3);
      v.err   = (v.regs == 2'd1) && v.rerr;
      v.en    = v.regw && (v.rd != 5'd0) && !v.err;
      v.e32   = ref_wb(32, v);
      v.e64   = ref_wb(64, v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_wbu_hs.md
YSYX_25060170_WBU_HS -- requirements
Module: ysyx_25060170_wbu_hs

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter RADDR_W, default 5, register-index width.
REQ-003 SHALL have parameter CNT_W, default 64, retire-counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  EXU result valid.
REQ-007 SHALL have port in_ready  output  1  WBU can accept a result.
REQ-008 SHALL have port exu_result_i  input  XLEN  ALU result, or load address when regS=1.
REQ-009 SHALL have port pc_i  input  XLEN  PC of the instruction.
REQ-010 SHALL have port csr_rdata_i  input  XLEN  old CSR value.
REQ-011 SHALL have port rd_i  input  RADDR_W  destination register.
REQ-012 SHALL have port regS  input  2  write-back source: 0 ALU, 1 memory, 2 PC+4, 3 CSR.
REQ-013 SHALL have port RegW  input  1  register write request.
REQ-014 SHALL have port ld_funct3_i  input  3  load size and sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
REQ-015 SHALL have port mem_rvalid  input  1  memory read data valid.
REQ-016 SHALL have port mem_rdata  input  XLEN  aligned memory word.
REQ-017 SHALL have port mem_rerr  input  1  memory read error; qualified by mem_rvalid.
REQ-018 SHALL have ports reg_write_en_o  output  1, reg_write_addr_o  output  RADDR_W, and reg_write_data_o  output  XLEN; together these form the register-file write port.
REQ-019 SHALL have ports commit_o  output  1, commit_pc_o  output  XLEN, and commit_err_o  output  1; these carry the one-cycle retire pulse, its PC, and its error flag.
REQ-020 SHALL have port retire_cnt_o  output  CNT_W  count of retired instructions.

Function
REQ-021 SHALL implement FSM states IDLE, WAIT_MEM and WRITE.
REQ-022 In IDLE, in_ready SHALL be 1; in WAIT_MEM and WRITE, in_ready SHALL be 0.
REQ-023 A handshake (in_valid & in_ready) SHALL register all inputs and transition IDLE->WRITE when regS≠1, or IDLE->WAIT_MEM when regS=1.
REQ-024 WAIT_MEM SHALL hold until mem_rvalid=1, then capture the extended load data and error flag and transition to WRITE; mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-025 WRITE SHALL last exactly one cycle and then return to IDLE; a new handshake is therefore possible in the cycle after WRITE.
REQ-026 Latency: a non-load accepted in cycle T SHALL write in T+1; a load SHALL write one cycle after the cycle in which mem_rvalid is sampled.
REQ-027 reg_write_en_o SHALL equal (state==WRITE) & RegW & (rd≠0) & ~err, using registered values.
REQ-028 reg_write_data_o SHALL select by source: ALU result for regS=0, extended load for regS=1, PC+4 (mod 2^XLEN) for regS=2, CSR data for regS=3.
REQ-029 Load extraction SHALL use byte offset = address[log2(XLEN/8)-1:0] and shift mem_rdata right by 8×offset.
REQ-030 Load extension SHALL sign-extend for lb, lh, lw(XLEN=64) and zero-extend for lbu, lhu, lwu; ld and lw(XLEN=32) SHALL pass the full word.
REQ-031 For XLEN=32, funct3 011 and 110 SHALL behave as lw; funct3 111 SHALL yield 0.
REQ-032 reg_write_addr_o SHALL present the registered rd at all times.
REQ-033 commit_o SHALL be 1 exactly during WRITE; commit_pc_o SHALL be the registered pc; commit_err_o SHALL be the captured mem_rerr (0 for non-loads).
REQ-034 retire_cnt_o SHALL increment by 1 on every WRITE cycle, including errored or rd=0 instructions, and SHALL wrap modulo 2^CNT_W.
REQ-035 Misalignment SHALL NOT be checked in this block; the offset shift SHALL apply regardless of alignment.

Reset
REQ-036 With rst=1 at a clock edge: state SHALL go to IDLE, the registered payload SHALL clear to 0, and retire_cnt_o SHALL become 0.
REQ-037 During and after reset, reg_write_en_o, commit_o and commit_err_o SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-038 Reset during WAIT_MEM or WRITE SHALL abort the instruction with no write and no commit; a later mem_rvalid SHALL be ignored.
REQ-039 rst SHALL take priority over in_valid and mem_rvalid in the same cycle.

Verification
REQ-040 ALU path: regS=0, rd=5, RegW=1, result 0x1234_5678 accepted at T -> at T+1 en=1, addr=5, data=0x12345678, commit=1; retire_cnt=1 at T+2.
REQ-041 lb sign-extend: address 0x8000_0003, mem_rdata 0x80FF_FF7F, mem_rvalid after 3 cycles -> data=0xFFFF_FF80, in_ready=0 throughout WAIT_MEM.
REQ-042 lhu on XLEN=64: offset 6, rdata 0xBEEF_0000_0000_0000 -> data=0x0000_0000_0000_BEEF.
REQ-043 Suppression: rd=0 with regS=2, and a load with mem_rerr=1 -> en=0, commit=1, commit_err=0 then 1, counter advances by 2.
REQ-044 Reset in WAIT_MEM followed by mem_rvalid -> no write, no commit, retire_cnt=0, in_ready=1.
REQ-045 Back-to-back traffic: in_valid held high for 4 ALU instructions -> handshakes every 2 cycles, 4 writes, retire_cnt=4; with CNT_W=4 preloaded via 15 retires, the next retire wraps to 0.
